// File: rtl/vga_timing_gen_if.sv
// Video-side bundle of vga_timing_gen: client pixel in, sync/enable/coordinates/RGB out.
// master = timing generator, slave = pixel source / display sink.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic [11:0]      rgb_in;
  logic             pix_en;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             active;
  logic             line_start;
  logic             frame_start;
  logic             hsync;
  logic             vsync;
  logic [3:0]       red;
  logic [3:0]       green;
  logic [3:0]       blue;

  modport master (
    input  rgb_in,
    output pix_en, x, y, active, line_start, frame_start,
    output hsync, vsync, red, green, blue
  );

  modport slave (
    output rgb_in,
    input  pix_en, x, y, active, line_start, frame_start,
    input  hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/pixel generator advancing on an internal pixel-tick enable.
// Define TEST_PATTERN_EN to replace rgb_in with internal 8-bar colour bars.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10
) (
  input logic                clk,
  input logic                rst,
  vga_timing_gen_if.master   vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             active_q, active_d;
  logic [11:0]      rgb_q, rgb_d;
  logic [11:0]      pixel;
  logic             pix_en, x_wrap, y_wrap;
  int unsigned      xi, yi;

  assign xi     = 32'(x_q);
  assign yi     = 32'(y_q);
  assign pix_en = (div_q == DIV_W'(CLK_DIV - 1));
  assign x_wrap = (xi == H_TOTAL - 1);
  assign y_wrap = (yi == V_TOTAL - 1);

`ifdef TEST_PATTERN_EN
  // Bar order white..black maps to r=~b[1], g=~b[2], b=~b[0] of the bar index.
  logic [2:0] bar;
  logic       unused_rgb_in;
  assign bar           = 3'((xi * 8) / H_ACTIVE);
  assign pixel         = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
  assign unused_rgb_in = ^vga.rgb_in;
`else
  assign pixel = vga.rgb_in;
`endif

  always_comb begin
    div_d    = pix_en ? '0 : div_q + DIV_W'(1);
    x_d      = x_q;
    y_d      = y_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    rgb_d    = rgb_q;
    if (pix_en) begin
      x_d = x_wrap ? '0 : x_q + CNT_W'(1);
      if (x_wrap) y_d = y_wrap ? '0 : y_q + CNT_W'(1);
      // Video registers take the pre-increment position: one tick behind x/y.
      hsync_d  = (xi >= HS_START && xi < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = (yi >= VS_START && yi < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      active_d = (xi < H_ACTIVE) && (yi < V_ACTIVE);
      rgb_d    = active_d ? pixel : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      active_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      rgb_q    <= rgb_d;
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.active      = active_q;
  assign vga.line_start  = pix_en & x_wrap;
  assign vga.frame_start = pix_en & x_wrap & y_wrap;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.red         = rgb_q[11:8];
  assign vga.green       = rgb_q[7:4];
  assign vga.blue        = rgb_q[3:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a tiny active-high-sync instance,
// checked every cycle against an arithmetic tick-count model and a set of literal expectations.
module tb_vga_timing_gen;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, div;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    int pix_en, x, y, active, ls, fs, hs, vs, rgb;
  } exp_t;

  localparam int BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

  cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0};
  cfg_t cfg_b = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  bit   chk_on = 1'b0;
  int   ca = 0, cb = 0;
  int   cap_a = 0, cap_b = 0;
  int   n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(10)) va ();
  vga_timing_gen_if #(.CNT_W(4))  vb ();

  vga_timing_gen #(.CNT_W(10)) dut_a (.clk(clk), .rst(rst_a), .vga(va));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4)
  ) dut_b (.clk(clk), .rst(rst_b), .vga(vb));

  // Outputs at clock c after reset: t ticks done, counter = position t, video = position t-1.
  function automatic exp_t model(cfg_t k, int c, int rgb_cap);
    exp_t e;
    int ht, vt, t, px, py;
    ht = k.ha + k.hf + k.hs + k.hb;
    vt = k.va + k.vf + k.vs + k.vb;
    t = c / k.div;
    e.pix_en = int'((c % k.div) == k.div - 1);
    e.x  = t % ht;
    e.y  = (t / ht) % vt;
    e.ls = int'(e.pix_en == 1 && e.x == ht - 1);
    e.fs = int'(e.ls == 1 && e.y == vt - 1);
    e.hs = int'(!k.hp);
    e.vs = int'(!k.vp);
    e.active = 0;
    e.rgb = 0;
    if (t > 0) begin
      px = (t - 1) % ht;
      py = ((t - 1) / ht) % vt;
      if (px >= k.ha + k.hf && px < k.ha + k.hf + k.hs) e.hs = int'(k.hp);
      if (py >= k.va + k.vf && py < k.va + k.vf + k.vs) e.vs = int'(k.vp);
      e.active = int'(px < k.ha && py < k.va);
`ifdef TEST_PATTERN_EN
      if (e.active == 1) e.rgb = BARS[px * 8 / k.ha];
`else
      if (e.active == 1) e.rgb = rgb_cap;
`endif
    end
    return e;
  endfunction

  task automatic cmp(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic timeout(string nm);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  always @(posedge clk) begin
    if (!rst_a && (ca % cfg_a.div) == cfg_a.div - 1) cap_a <= int'(va.rgb_in);
    if (!rst_b && (cb % cfg_b.div) == cfg_b.div - 1) cap_b <= int'(vb.rgb_in);
    ca <= rst_a ? 0 : ca + 1;
    cb <= rst_b ? 0 : cb + 1;
  end

  always @(negedge clk) begin
    exp_t ea, eb;
    if (chk_on) begin
      ea = model(cfg_a, ca, cap_a);
      eb = model(cfg_b, cb, cap_b);
      cmp("a.pix_en", int'(va.pix_en), ea.pix_en);
      cmp("a.x", int'(va.x), ea.x);
      cmp("a.y", int'(va.y), ea.y);
      cmp("a.active", int'(va.active), ea.active);
      cmp("a.line_start", int'(va.line_start), ea.ls);
      cmp("a.frame_start", int'(va.frame_start), ea.fs);
      cmp("a.hsync", int'(va.hsync), ea.hs);
      cmp("a.vsync", int'(va.vsync), ea.vs);
      cmp("a.rgb", int'({va.red, va.green, va.blue}), ea.rgb);
      cmp("b.pix_en", int'(vb.pix_en), eb.pix_en);
      cmp("b.x", int'(vb.x), eb.x);
      cmp("b.y", int'(vb.y), eb.y);
      cmp("b.active", int'(vb.active), eb.active);
      cmp("b.line_start", int'(vb.line_start), eb.ls);
      cmp("b.frame_start", int'(vb.frame_start), eb.fs);
      cmp("b.hsync", int'(vb.hsync), eb.hs);
      cmp("b.vsync", int'(vb.vsync), eb.vs);
      cmp("b.rgb", int'({vb.red, vb.green, vb.blue}), eb.rgb);
    end
  end

  // rgb_in for instance A is 5A3 on every tick edge and junk in between.
  initial begin
    va.rgb_in = 12'h5A3;
    vb.rgb_in = 12'hABC;
    forever begin
      @(negedge clk);
      va.rgb_in = ((ca % cfg_a.div) == cfg_a.div - 1) ? 12'h5A3 : 12'($urandom);
    end
  end

  task automatic wait_a_x(int tgt);
    int n = 0;
    while (int'(va.x) != tgt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) timeout("wait_a_x");
  endtask

  initial begin
    int k, n, m, act_cnt, abc_cnt, stray, hs_cnt, vs_cnt;
`ifdef TEST_PATTERN_EN
    int exp_x0 = 12'hFFF, exp_x80 = 12'hFF0, exp_x560 = 12'h000;
`else
    int exp_x0 = 12'h5A3, exp_x80 = 12'h5A3, exp_x560 = 12'h5A3;
`endif
    @(negedge clk);
    chk_on = 1'b1;
    repeat (4) @(negedge clk);
    cmp("rst_a_hsync", int'(va.hsync), 1);
    cmp("rst_a_vsync", int'(va.vsync), 1);
    cmp("rst_a_rgb", int'({va.red, va.green, va.blue}), 0);
    cmp("rst_a_x", int'(va.x), 0);
    cmp("rst_a_y", int'(va.y), 0);
    cmp("rst_b_hsync_pol", int'(vb.hsync), 0);
    cmp("rst_b_vsync_pol", int'(vb.vsync), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    k = 1;
    while (!va.pix_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    cmp("first_pix_en_clk", k, 4);

    wait_a_x(1);
    cmp("rgb_at_regx0", int'({va.red, va.green, va.blue}), exp_x0);
    wait_a_x(81);
    cmp("rgb_at_regx80", int'({va.red, va.green, va.blue}), exp_x80);
    wait_a_x(561);
    cmp("rgb_at_regx560", int'({va.red, va.green, va.blue}), exp_x560);

    n = 0;
    while (va.hsync && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) timeout("hsync_fall");
    cmp("x_at_hsync_fall", int'(va.x), 657);
    n = 0;
    while (!va.hsync && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cmp("hsync_low_clks", n, 384);
    m = n;
    while (va.hsync && m < 4000) begin
      @(negedge clk);
      m++;
    end
    cmp("hsync_period_clks", m, 3200);

    n = 0;
    while (!vb.frame_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("b_frame_start");
    act_cnt = 0; abc_cnt = 0; stray = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 98; i++) begin
      if (vb.active) act_cnt++;
      if (vb.active && {vb.red, vb.green, vb.blue} == 12'hABC) abc_cnt++;
      if (!vb.active && {vb.red, vb.green, vb.blue} != 12'h000) stray++;
      if (vb.hsync) hs_cnt++;
      if (vb.vsync) vs_cnt++;
      @(negedge clk);
    end
    cmp("b_frame_start_period", int'(vb.frame_start), 1);
    cmp("b_active_ticks", act_cnt, 32);
`ifndef TEST_PATTERN_EN
    cmp("b_rgb_abc_ticks", abc_cnt, 32);
`endif
    cmp("b_rgb_outside_active", stray, 0);
    cmp("b_hsync_high_ticks", hs_cnt, 14);
    cmp("b_vsync_high_ticks", vs_cnt, 14);

    n = 0;
    while (!(int'(vb.x) == 5 && int'(vb.y) == 3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("b_midframe_pos");
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    cmp("b_midrst_x", int'(vb.x), 0);
    cmp("b_midrst_y", int'(vb.y), 0);
    cmp("b_midrst_active", int'(vb.active), 0);
    k = 1;
    while (!vb.frame_start && k < 300) begin
      @(negedge clk);
      k++;
    end
    cmp("b_fs_after_midrst_clks", k, 98);

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
